// File: rtl/regfile_32x64.sv
// 32x64 architectural register file: two combinational read ports, one write port.
// X31 (XZR) has no storage; it always reads zero and ignores writes.
module regfile_32x64 #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [3:0]       bank_en;
  logic [31:0]      en;
  logic [WIDTH-1:0] mux_in [32];
  logic             unused_en;

  // 2-to-4 bank select gated by RegWrite, so X address bits stay harmless
  assign bank_en = {4{RegWrite}} & (4'b0001 << WriteRegister[4:3]);

  for (genvar b = 0; b < 4; b++) begin : g_dec
    assign en[b*8 +: 8] = {8{bank_en[b]}} & (8'b0000_0001 << WriteRegister[2:0]);
  end

  assign unused_en = en[ZERO_REG];

  for (genvar i = 0; i < NREGS; i++) begin : g_rf
    if (i == ZERO_REG) begin : g_zero
      assign mux_in[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (en[i]) begin
          q <= WriteData;
        end
      end
      assign mux_in[i] = q;
    end
  end

  // 32:1 read select as two 4:1 levels and a final 2:1
  function automatic logic [WIDTH-1:0] rd(input logic [4:0] a);
    logic [WIDTH-1:0] l1 [8];
    logic [WIDTH-1:0] l2 [2];
    for (int g = 0; g < 8; g++) begin
      l1[g] = mux_in[{g[2:0], a[1:0]}];
    end
    for (int g = 0; g < 2; g++) begin
      l2[g] = l1[{g[0], a[3:2]}];
    end
    return a[4] ? l2[1] : l2[0];
  endfunction

  assign ReadData1 = rd(ReadRegister1);
  assign ReadData2 = rd(ReadRegister2);

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64.
// Read expectations are queued when stimulus is driven and checked after settling.
module tb_regfile_32x64;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  regfile_32x64 dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  exp_t        sb [$];
  vec_t        tbl [$];
  logic [63:0] mdl [32];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [63:0] pat(input int i);
    logic [63:0] base;
    base = 64'hA5A5_0000_0000_0000;
    return base | 64'(i);
  endfunction

  task automatic drive(input logic rw, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [63:0] e1,
                       input logic [63:0] e2);
    exp_t e;
    RegWrite      = rw;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
  endtask

  task automatic check(input string nm);
    exp_t e;
    #1;
    e = sb.pop_front();
    n_checks++;
    if (ReadData1 !== e.e1) begin
      n_fail++;
      $display("FAIL %s port1 addr %0d: got %h expected %h",
               nm, ReadRegister1, ReadData1, e.e1);
    end
    n_checks++;
    if (ReadData2 !== e.e2) begin
      n_fail++;
      $display("FAIL %s port2 addr %0d: got %h expected %h",
               nm, ReadRegister2, ReadData2, e.e2);
    end
  endtask

  // one clock edge; the bench model follows the architectural rules
  task automatic cyc();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      mdl[WriteRegister] = WriteData;
    end
    @(negedge clk);
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i), mdl[i], mdl[31 - i]);
      check(nm);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0);
    void'(sb.pop_front());
    @(negedge clk);
    cyc();
    reset = 1'b0;
    sweep("reset_sweep");

    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), pat(i), 5'(i), 5'd31, 64'h0, 64'h0);
      void'(sb.pop_front());
      cyc();
    end
    sweep("write_all");

    tbl.push_back('{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30, 64'h0, pat(30)});
    tbl.push_back('{1'b0, 5'd0, 64'h0, 5'd31, 5'd0, 64'h0, pat(0)});
    tbl.push_back('{1'b1, 5'd5, 64'h1111, 5'd5, 5'd5, pat(5), pat(5)});
    tbl.push_back('{1'b1, 5'd5, 64'h2222, 5'd5, 5'd5, 64'h1111, 64'h1111});
    tbl.push_back('{1'b0, 5'd5, 64'h3333, 5'd5, 5'd5, 64'h2222, 64'h2222});
    tbl.push_back('{1'b0, 5'd7, 64'hDEAD_BEEF, 5'd7, 5'd7, pat(7), pat(7)});
    tbl.push_back('{1'b0, 5'd7, 64'hDEAD_BEEF, 5'd7, 5'd6, pat(7), pat(6)});
    tbl.push_back('{1'b0, 5'd7, 64'hDEAD_BEEF, 5'd7, 5'd8, pat(7), pat(8)});
    tbl.push_back('{1'b0, 5'd0, 64'h0, 5'd7, 5'd31, pat(7), 64'h0});
    tbl.push_back('{1'b1, 5'd3, 64'hAAAA, 5'd3, 5'd4, pat(3), pat(4)});
    tbl.push_back('{1'b1, 5'd3, 64'hBBBB, 5'd3, 5'd3, 64'hAAAA, 64'hAAAA});
    tbl.push_back('{1'b1, 5'd3, 64'hCCCC, 5'd4, 5'd3, pat(4), 64'hBBBB});
    tbl.push_back('{1'b0, 5'd3, 64'h0, 5'd3, 5'd3, 64'hCCCC, 64'hCCCC});
    tbl.push_back('{1'b1, 5'd10, 64'h1234, 5'd10, 5'd9, pat(10), pat(9)});
    tbl.push_back('{1'b0, 5'd0, 64'h0, 5'd10, 5'd31, 64'h1234, 64'h0});

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rw, tbl[k].wa, tbl[k].wd, tbl[k].r1, tbl[k].r2,
            tbl[k].e1, tbl[k].e2);
      check($sformatf("vec%0d", k));
      cyc();
    end
    sweep("post_table");

    reset = 1'b1;
    drive(1'b1, 5'd10, 64'h5678, 5'd10, 5'd11, 64'h1234, pat(11));
    check("reset_prio_pre");
    cyc();
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 5'd10, 5'd11, 64'h0, 64'h0);
    check("reset_prio_post");
    sweep("reset_prio_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
